// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential signed divider: data width,
// 3-bit state encodings (also decoded by the control unit) and the debug view.
package div_seq_ctrl_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Debug view of the sequencer, exported so checkers can follow the FSM.
    typedef struct packed {
        logic [2:0] state;
        logic [4:0] count;
        logic       sub_cout;
    } div_dbg_t;

    // Unsigned magnitude of a two's complement value; |-2^31| is 32'h8000_0000.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (-v) : v;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
// Handshake: start is a request the divider samples only while idle; it carries
// no ready signal, so a start seen while busy or in the done cycle is dropped.
// done is a one-cycle pulse and quotient/remainder/div_by_zero are valid from
// that cycle, held until the next accepted start.
interface div_seq_ctrl_if;
    import div_seq_ctrl_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_seq_ctrl_sub.sv
// Existing 32-bit subtractor shared with the datapath: sum = Ra - Rb - cin.
// cout is the inverted borrow (1 when no borrow occurred).
module sub_32bit
    import div_seq_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] diff;

    // Extended subtraction so the borrow appears in the top bit.
    always_comb begin
        diff = {1'b0, Ra} - {1'b0, Rb} - {{WIDTH{1'b0}}, cin};
        sum  = diff[WIDTH-1:0];
        cout = ~diff[WIDTH];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed 32-bit divider: restoring shift/subtract, one quotient
// bit per cycle, using a single shared sub_32bit. Truncating division with
// the remainder taking the dividend's sign.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    div_seq_ctrl_if.slave      bus,
    output div_dbg_t           dbg
);

    logic [2:0]       state_q,       state_d;
    logic [4:0]       count_q,       count_d;
    logic [WIDTH-1:0] dividend_q,    dividend_d;
    logic [WIDTH-1:0] divisor_q,     divisor_d;
    logic [WIDTH-1:0] q_q,           q_d;
    logic [WIDTH-1:0] m_q,           m_d;
    logic [WIDTH-1:0] r_q,           r_d;
    logic             sign_quo_q,    sign_quo_d;
    logic             sign_rem_q,    sign_rem_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             dbz_q,         dbz_d;

    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] sub_sum;
    logic             sub_cout;

    // Partial remainder shifted left with the next dividend bit; R < M <= 2^31
    // keeps R[31] clear, so nothing is lost by dropping it.
    assign trial = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    sub_32bit u_sub (
        .Ra   (trial),
        .Rb   (m_q),
        .cin  (1'b0),
        .sum  (sub_sum),
        .cout (sub_cout)
    );

    // Next-state, datapath and result-register updates for each FSM state.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        q_d         = q_q;
        m_d         = m_q;
        r_d         = r_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    state_d    = ST_PREP;
                end
            end
            ST_PREP: begin
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    q_d        = abs_val(dividend_q);
                    m_d        = abs_val(divisor_q);
                    r_d        = '0;
                    sign_quo_d = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
                    sign_rem_d = dividend_q[WIDTH-1];
                    count_d    = 5'd31;
                    state_d    = ST_ITER;
                end
            end
            ST_ITER: begin
                // Local unsigned compare decides; the subtractor only supplies T - M.
                q_d = {q_q[WIDTH-2:0], 1'b0};
                if (trial >= m_q) begin
                    r_d    = sub_sum;
                    q_d[0] = 1'b1;
                end else begin
                    r_d = trial;
                end
                if (count_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            ST_FIX: begin
                quotient_d  = sign_quo_q ? (-q_q) : q_q;
                remainder_d = sign_rem_q ? (-r_q) : r_q;
                dbz_d       = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous clear that abandons any operation.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            q_q         <= '0;
            m_q         <= '0;
            r_q         <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            q_q         <= q_d;
            m_q         <= m_d;
            r_q         <= r_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Status decoded from the state; results come straight from their registers.
    always_comb begin
        bus.busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
        bus.done        = (state_q == ST_DONE);
        bus.quotient    = quotient_q;
        bus.remainder   = remainder_q;
        bus.div_by_zero = dbz_q;
        dbg.state       = state_q;
        dbg.count       = count_q;
        dbg.sub_cout    = sub_cout;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases from the block's
// behaviour description plus randomized operands against a reference model
// that uses plain signed 64-bit arithmetic.
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    logic     clock = 1'b0;
    logic     clear;
    div_dbg_t dbg;
    int       checks = 0;
    int       errors = 0;
    logic [2*WIDTH:0] exp_q[$];

    div_seq_ctrl_if bus();

    div_seq_ctrl dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus),
        .dbg   (dbg)
    );

    // Clock
    always #5 clock = ~clock;

    // Reference: {div_by_zero, quotient, remainder} from truncating 64-bit division.
    function automatic logic [2*WIDTH:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint la, lb, lq, lr;
        logic [31:0] q, r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        la = longint'(signed'(a));
        lb = longint'(signed'(b));
        lq = la / lb;
        lr = la % lb;
        q  = lq[31:0];
        r  = lr[31:0];
        return {1'b0, q, r};
    endfunction

    // Driver: present operands with start for one edge (the accept edge).
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock);
        #1 bus.start = 1'b0;
    endtask

    // Wait for done, sampling at negedges; lat is the cycle index after accept (-1 on timeout).
    task automatic wait_done(output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                lat = c;
                if (bus.busy !== 1'b0) busy_bad++;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", bus.div_by_zero); end
        checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
        checks++; if (dbg.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg.state, ST_IDLE); end
        clear = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta[5] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'd9};
        logic [31:0] tb[5] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] tq[5] = '{32'h0000_000E, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'd9};
        logic [31:0] tr[5] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0002, 32'd0, 32'd0};
        int lat, busy_bad;
        for (int i = 0; i < 5; i++) begin
            drive_start(ta[i], tb[i]);
            wait_done(lat, busy_bad);
            checks++; if (lat != 35) begin errors++; $display("FAIL dir%0d_latency got %0d want 35", i, lat); end
            checks++; if (busy_bad != 0) begin errors++; $display("FAIL dir%0d_busy bad_cycles %0d want 0", i, busy_bad); end
            checks++; if (bus.quotient !== tq[i]) begin errors++; $display("FAIL dir%0d_quotient got %h want %h", i, bus.quotient, tq[i]); end
            checks++; if (bus.remainder !== tr[i]) begin errors++; $display("FAIL dir%0d_remainder got %h want %h", i, bus.remainder, tr[i]); end
            checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dir%0d_dbz got %0b want 0", i, bus.div_by_zero); end
            @(negedge clock);
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %0b want 0", i, bus.done); end
        end
    endtask

    task automatic test_div_zero();
        int lat, busy_bad;
        drive_start(32'h1234_5678, 32'd0);
        wait_done(lat, busy_bad);
        checks++; if (lat != 2) begin errors++; $display("FAIL dz_latency got %0d want 2", lat); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", bus.div_by_zero); end
        checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient got %h want ffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 32'h1234_5678) begin errors++; $display("FAIL dz_remainder got %h want 12345678", bus.remainder); end
        // A following normal division clears the flag.
        drive_start(32'd7, 32'd2);
        wait_done(lat, busy_bad);
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %0b want 0", bus.div_by_zero); end
        checks++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd1) begin errors++; $display("FAIL dz_next got %h r %h want 3 r 1", bus.quotient, bus.remainder); end
    endtask

    task automatic test_ignored_start();
        int lat = -1;
        drive_start(32'd100, 32'd7);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            bus.start = (c == 5 || c == 20);
            bus.dividend = $urandom;
            bus.divisor = 32'd3;
        end
        bus.start = 1'b0;
        checks++; if (lat != 35) begin errors++; $display("FAIL ign_latency got %0d want 35", lat); end
        checks++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin errors++; $display("FAIL ign_result got %h r %h want e r 2", bus.quotient, bus.remainder); end
    endtask

    task automatic test_start_held();
        int done_cyc[$];
        int lat, busy_bad;
        @(negedge clock);
        bus.start = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor = 32'd7;
        @(posedge clock);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1) done_cyc.push_back(c);
        end
        bus.start = 1'b0;
        checks++; if (done_cyc.size() != 2) begin errors++; $display("FAIL held_done_count got %0d want 2", done_cyc.size()); end
        checks++; if (done_cyc.size() < 2 || done_cyc[0] != 35 || done_cyc[1] != 71) begin
            errors++; $display("FAIL held_done_cycles got %p want 35 71", done_cyc);
        end
        wait_done(lat, busy_bad);
        checks++; if (lat < 0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            errors++; $display("FAIL held_third got lat %0d %h r %h want e r 2", lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_clear_mid();
        int lat, busy_bad;
        drive_start(32'd100, 32'd7);
        repeat (9) @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL clr_status got busy %0b done %0b want 0 0", bus.busy, bus.done); end
        checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL clr_outputs got %h r %h dbz %0b want 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        drive_start(32'd50, 32'd5);
        wait_done(lat, busy_bad);
        checks++; if (lat != 35) begin errors++; $display("FAIL clr_next_latency got %0d want 35", lat); end
        checks++; if (bus.quotient !== 32'd10 || bus.remainder !== 32'd0) begin errors++; $display("FAIL clr_next_result got %h r %h want a r 0", bus.quotient, bus.remainder); end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2*WIDTH:0] e;
        int lat, busy_bad, want_lat;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                4: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            exp_q.push_back(ref_div(a, b));
            want_lat = (b == 32'd0) ? 2 : 35;
            drive_start(a, b);
            wait_done(lat, busy_bad);
            e = exp_q.pop_front();
            checks++; if (lat != want_lat) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, want_lat); end
            checks++; if ({bus.div_by_zero, bus.quotient, bus.remainder} !== e) begin
                errors++; $display("FAIL rnd%0d_result %h/%h got dbz %0b %h r %h want dbz %0b %h r %h", i, a, b,
                    bus.div_by_zero, bus.quotient, bus.remainder, e[2*WIDTH], e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
            end
            checks++; if (busy_bad != 0) begin errors++; $display("FAIL rnd%0d_busy bad_cycles %0d want 0", i, busy_bad); end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        clear        = 1'b1;
        test_reset();
        test_directed();
        test_div_zero();
        test_ignored_start();
        test_start_held();
        test_clear_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
